// File: rtl/sub_nibble_serial.sv
// sub_nibble_serial: multi-cycle N-bit subtractor, Diff = A - B - Bin.
// A single 4-bit adder slice walks from the LSB nibble to the MSB nibble,
// one nibble per clock, computing A + ~B + ~Bin with a registered carry.
// start/done handshake:
//   - start is sampled only in IDLE or DONE; a high start at such an edge
//     latches A/B/Bin and begins a new operation (start in RUN is ignored).
//   - done is a one-cycle pulse; Diff/Borrow/Ofl/Zero are final in that
//     cycle and hold until the next accepted start (Diff clears on accept).
// All outputs come straight from flops; state_dbg exposes the FSM state.
module sub_nibble_serial #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Diff,
  output logic         Borrow,
  output logic         Ofl,
  output logic         Zero,
  output logic [1:0]   state_dbg
);

  localparam int NS = N / 4;
  localparam int CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  diff_q, diff_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          borrow_q, borrow_d;
  logic          ofl_q, ofl_d;
  logic          zero_q, zero_d;

  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    sum5;
  logic [N-1:0]  diff_full;
  logic          last_slice;

  // Slice datapath: select the current nibble pair and add with the carry.
  always_comb begin
    a_nib = 4'd0;
    b_nib = 4'd0;
    for (int k = 0; k < NS; k++) begin
      if (cnt_q == CW'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
    sum5 = {1'b0, a_nib} + {1'b0, ~b_nib} + {4'd0, carry_q};
    diff_full = diff_q;
    for (int k = 0; k < NS; k++) begin
      if (cnt_q == CW'(k)) begin
        diff_full[4*k +: 4] = sum5[3:0];
      end
    end
    last_slice = (cnt_q == CW'(NS - 1));
  end

  // Next-state and next-output logic for the IDLE/RUN/DONE controller.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    borrow_d = borrow_q;
    ofl_d    = ofl_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~Bin;
          diff_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        diff_d  = diff_full;
        carry_d = sum5[4];
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          cnt_d    = '0;
          borrow_d = ~sum5[4];
          ofl_d    = (a_q[N-1] != b_q[N-1]) && (diff_full[N-1] != a_q[N-1]);
          zero_d   = (diff_full == '0);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset discards any partial work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      borrow_q <= 1'b0;
      ofl_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      borrow_q <= borrow_d;
      ofl_q    <= ofl_d;
      zero_q   <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign Diff      = diff_q;
  assign Borrow    = borrow_q;
  assign Ofl       = ofl_q;
  assign Zero      = zero_q;
  assign state_dbg = state_q;

endmodule
